// File: rtl/rs_latch_driver.sv
`default_nettype none
// ============================================================================
// Module   : rs_latch_driver
// Brief    : Debounced push-button front end producing clean, mutually
//            exclusive S/R pulses with dead time for a gated RS latch.
// Revision : 1.0 - initial release
// ============================================================================
module rs_latch_driver #(
    parameter int DEB_CYCLES   = 4,
    parameter int PULSE_CYCLES = 2,
    parameter int GAP_CYCLES   = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic set_btn,
    input  logic clr_btn,
    output logic S,
    output logic R,
    output logic busy,
    output logic q_exp,
    output logic conflict,
    output logic overrun
);

    localparam int   c_DEB_W   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int   c_TMR_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int   c_TMR_W   = (c_TMR_MAX > 1) ? $clog2(c_TMR_MAX) : 1;
    localparam logic c_KIND_SET = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PULSE_S = 2'd1,
        ST_PULSE_R = 2'd2,
        ST_GAP     = 2'd3
    } state_t;

    logic [1:0] w_raw;
    logic [1:0] w_rise;

    assign w_raw = {clr_btn, set_btn};

    // Bit 0 is the set button, bit 1 the clear button.
    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_btn
        logic               r_sync1;
        logic               r_sync2;
        logic               r_deb;
        logic               r_deb_d;
        logic [c_DEB_W-1:0] r_cnt;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_sync1 <= 1'b0;
                r_sync2 <= 1'b0;
                r_deb   <= 1'b0;
                r_deb_d <= 1'b0;
                r_cnt   <= '0;
            end else begin
                r_sync1 <= w_raw[gi];
                r_sync2 <= r_sync1;
                r_deb_d <= r_deb;
                if (r_sync2 == r_deb) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_DEB_W'(DEB_CYCLES - 1)) begin
                    r_deb <= ~r_deb;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + c_DEB_W'(1);
                end
            end
        end

        assign w_rise[gi] = r_deb & ~r_deb_d;
    end

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_TMR_W-1:0]   r_tmr;
    logic [c_TMR_W-1:0]   w_tmr_nxt;
    logic                 w_accept;
    logic                 w_pulse_end;

    logic r_slot_valid;
    logic r_slot_kind;
    logic w_slot_valid_nxt;
    logic w_slot_kind_nxt;
    logic w_conflict;
    logic w_overrun;

    logic r_busy;
    logic r_q;
    logic r_conflict;
    logic r_overrun;

    always_comb begin
        w_state_nxt = r_state;
        w_tmr_nxt   = r_tmr;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_slot_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (r_slot_kind == c_KIND_SET) ? ST_PULSE_S : ST_PULSE_R;
                    w_tmr_nxt   = '0;
                end
            end
            ST_PULSE_S, ST_PULSE_R: begin
                if (r_tmr == c_TMR_W'(PULSE_CYCLES - 1)) begin
                    w_state_nxt = ST_GAP;
                    w_tmr_nxt   = '0;
                end else begin
                    w_tmr_nxt = r_tmr + c_TMR_W'(1);
                end
            end
            ST_GAP: begin
                if (r_tmr == c_TMR_W'(GAP_CYCLES - 1)) begin
                    w_state_nxt = ST_IDLE;
                    w_tmr_nxt   = '0;
                end else begin
                    w_tmr_nxt = r_tmr + c_TMR_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_tmr_nxt   = '0;
            end
        endcase
    end

    assign w_pulse_end = ((r_state == ST_PULSE_S) || (r_state == ST_PULSE_R)) &&
                         (w_state_nxt == ST_GAP);

    // A request landing on the accept edge refills the slot rather than
    // counting as an overrun of the command being consumed.
    always_comb begin
        w_slot_valid_nxt = r_slot_valid & ~w_accept;
        w_slot_kind_nxt  = r_slot_kind;
        w_conflict       = 1'b0;
        w_overrun        = 1'b0;
        if (w_rise[0] && w_rise[1]) begin
            w_conflict = 1'b1;
        end else if (w_rise[0] || w_rise[1]) begin
            w_overrun        = r_slot_valid & ~w_accept & (r_slot_kind != w_rise[0]);
            w_slot_valid_nxt = 1'b1;
            w_slot_kind_nxt  = w_rise[0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_tmr        <= '0;
            r_slot_valid <= 1'b0;
            r_slot_kind  <= 1'b0;
            r_busy       <= 1'b0;
            r_q          <= 1'b0;
            r_conflict   <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_tmr        <= w_tmr_nxt;
            r_slot_valid <= w_slot_valid_nxt;
            r_slot_kind  <= w_slot_kind_nxt;
            // busy also covers the first IDLE cycle after GAP
            r_busy       <= (w_state_nxt != ST_IDLE) || (r_state == ST_GAP);
            r_conflict   <= w_conflict;
            r_overrun    <= w_overrun;
            if (w_pulse_end) begin
                r_q <= (r_state == ST_PULSE_S);
            end
        end
    end

    assign S        = (r_state == ST_PULSE_S);
    assign R        = (r_state == ST_PULSE_R);
    assign busy     = r_busy;
    assign q_exp    = r_q;
    assign conflict = r_conflict;
    assign overrun  = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_rs_latch_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_rs_latch_driver
// Brief    : Self-checking bench: vector tables, corner sequences and random
//            stimulus against a timeline-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rs_latch_driver;

    localparam int M_DEB = 4;
    localparam int M_P   = 2;
    localparam int M_G   = 1;

    logic clk = 1'b0;
    logic rst;
    logic set1, clr1, set2, clr2;
    logic S1, R1, busy1, q1, conf1, ovr1;
    logic S2, R2, busy2, q2, conf2, ovr2;
    logic [5:0] out1, out2;

    int n_vec = 0;
    int n_err = 0;
    bit m_en  = 1'b0;

    always #5 clk = ~clk;

    rs_latch_driver u_dut (
        .clk(clk), .rst(rst), .set_btn(set1), .clr_btn(clr1),
        .S(S1), .R(R1), .busy(busy1), .q_exp(q1), .conflict(conf1), .overrun(ovr1)
    );

    rs_latch_driver #(.DEB_CYCLES(4), .PULSE_CYCLES(8), .GAP_CYCLES(1)) u_dut_long (
        .clk(clk), .rst(rst), .set_btn(set2), .clr_btn(clr2),
        .S(S2), .R(R2), .busy(busy2), .q_exp(q2), .conflict(conf2), .overrun(ovr2)
    );

    assign out1 = {S1, R1, busy1, q1, conf1, ovr1};
    assign out2 = {S2, R2, busy2, q2, conf2, ovr2};

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // Reference model: button timelines, a one-entry slot and a busy window
    logic [M_DEB-1:0] m_hist [2];
    bit m_s1 [2];
    bit m_s2 [2];
    bit m_deb [2];
    bit m_deb_prev [2];
    bit m_sv, m_sk, m_act, m_kind, m_q, m_busy, m_conf, m_ovr;
    int m_t;

    always @(posedge clk) begin
        bit rs, rc, acc, ended, old_sv, old_sk;
        bit raw [2];
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                m_s1[b] = 0; m_s2[b] = 0; m_deb[b] = 0; m_deb_prev[b] = 0; m_hist[b] = '0;
            end
            m_sv = 0; m_sk = 0; m_act = 0; m_kind = 0; m_q = 0;
            m_busy = 0; m_conf = 0; m_ovr = 0; m_t = 0;
        end else begin
            raw[0] = set1;
            raw[1] = clr1;
            rs = m_deb[0] && !m_deb_prev[0];
            rc = m_deb[1] && !m_deb_prev[1];
            for (int b = 0; b < 2; b++) begin
                m_deb_prev[b] = m_deb[b];
                m_hist[b] = {m_hist[b][M_DEB-2:0], m_s2[b]};
                if (m_hist[b] == {M_DEB{~m_deb[b]}}) m_deb[b] = ~m_deb[b];
                m_s2[b] = m_s1[b];
                m_s1[b] = raw[b];
            end
            old_sv = m_sv;
            old_sk = m_sk;
            acc    = !m_act && m_sv;
            ended  = 0;
            if (m_act) begin
                m_t = m_t + 1;
                if (m_t == M_P) m_q = m_kind;
                if (m_t == M_P + M_G) begin
                    m_act = 0;
                    ended = 1;
                end
            end
            if (acc) begin
                m_act = 1; m_t = 0; m_kind = m_sk; m_sv = 0;
            end
            m_conf = 0;
            m_ovr  = 0;
            if (rs && rc) begin
                m_conf = 1;
            end else if (rs || rc) begin
                if (old_sv && !acc && (old_sk != rs)) m_ovr = 1;
                m_sv = 1;
                m_sk = rs;
            end
            m_busy = m_act || ended;
        end
    end

    always @(negedge clk) begin
        if (m_en) begin
            check("model", {2'b0, out1},
                  {2'b0, m_act && m_kind && (m_t < M_P), m_act && !m_kind && (m_t < M_P),
                   m_busy, m_q, m_conf, m_ovr});
            check("s_and_r_exclusive", {6'b0, S1 & R1, S2 & R2}, 8'd0);
        end
    end

    typedef struct {
        logic       set;
        logic       clr;
        logic [5:0] exp;   // {S, R, busy, q_exp, conflict, overrun}
    } vec_t;

    vec_t tbl [64];

    task automatic do_reset();
        @(negedge clk);
        rst = 1; set1 = 0; clr1 = 0; set2 = 0; clr2 = 0;
        repeat (3) @(negedge clk);
        check("reset_state", {2'b0, out1}, 8'd0);
        check("reset_state_long", {2'b0, out2}, 8'd0);
        rst = 0;
    endtask

    task automatic apply_tbl(input string name, input int n, input bit on2);
        for (int c = 0; c < n; c++) begin
            if (on2) begin
                set2 = tbl[c].set; clr2 = tbl[c].clr;
            end else begin
                set1 = tbl[c].set; clr1 = tbl[c].clr;
            end
            @(negedge clk);
            check(name, {2'b0, on2 ? out2 : out1}, {2'b0, tbl[c].exp});
        end
    endtask

    int hs, hc;

    initial begin
        rst = 1; set1 = 0; clr1 = 0; set2 = 0; clr2 = 0;
        do_reset();
        m_en = 1'b1;

        // set held from cycle 0
        for (int c = 0; c < 14; c++) begin
            tbl[c].set = 1'b1; tbl[c].clr = 1'b0;
            tbl[c].exp = {(c >= 7 && c <= 8), 1'b0, (c >= 7 && c <= 10), (c >= 9), 2'b00};
        end
        do_reset();
        apply_tbl("set_held", 14, 1'b0);

        // bouncing set button never gets through
        for (int c = 0; c < 40; c++) begin
            tbl[c].set = (c < 20) ? ((c / 2) % 2 == 0) : 1'b0;
            tbl[c].clr = 1'b0;
            tbl[c].exp = 6'b0;
        end
        do_reset();
        apply_tbl("bounce", 40, 1'b0);

        // simultaneous presses
        for (int c = 0; c < 20; c++) begin
            tbl[c].set = 1'b1; tbl[c].clr = 1'b1;
            tbl[c].exp = {4'b0000, (c == 6), 1'b0};
        end
        do_reset();
        apply_tbl("conflict", 20, 1'b0);

        // clr queued behind a running S pulse
        for (int c = 0; c < 18; c++) begin
            tbl[c].set = 1'b1; tbl[c].clr = (c >= 2);
            tbl[c].exp = {(c >= 7 && c <= 8), (c >= 11 && c <= 12), (c >= 7 && c <= 14),
                          (c >= 9 && c <= 12), 2'b00};
        end
        do_reset();
        apply_tbl("set_then_clr", 18, 1'b0);

        // long-pulse instance: clr pending, then set re-pressed -> overrun
        for (int c = 0; c < 30; c++) begin
            tbl[c].set = (c < 4) || (c >= 8);
            tbl[c].clr = (c >= 3);
            tbl[c].exp = {(c >= 7 && c <= 14) || (c >= 17 && c <= 24), 1'b0,
                          (c >= 7 && c <= 26), (c >= 15), 1'b0, (c == 14)};
        end
        do_reset();
        apply_tbl("overrun", 30, 1'b1);

        // reset in the first PULSE_S cycle, button still held afterwards
        do_reset();
        set1 = 1;
        repeat (8) @(negedge clk);
        check("pulse_start", {7'b0, S1}, 8'd1);
        rst = 1;
        @(negedge clk);
        check("rst_mid_pulse", {2'b0, out1}, 8'd0);
        @(negedge clk);
        rst = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            check("held_thru_rst", {7'b0, S1}, {7'b0, (c == 7 || c == 8)});
        end

        // random button activity with occasional reset
        do_reset();
        hs = 0;
        hc = 0;
        for (int c = 0; c < 3000; c++) begin
            if (hs == 0) begin
                set1 = ~set1;
                hs = $urandom_range(1, 14);
            end else begin
                hs--;
            end
            if (hc == 0) begin
                clr1 = ~clr1;
                hc = $urandom_range(1, 14);
            end else begin
                hc--;
            end
            rst = ($urandom_range(0, 499) == 0);
            @(negedge clk);
        end
        rst = 0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
